vga_tile_framebuffer: RTL and testbench



---
 rtl/vga_tile_framebuffer.sv | 163 ++++++++++++++++
 tb/tb_vga_tile_framebuffer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_tile_framebuffer.sv
// Tile framebuffer for a 640x480 VGA timing stage.
// The screen is an 80x60 grid of 8x8 single-colour cells held in dual-port RAM.
// It also has a write port, a hardware clear engine, frame-synchronous vertical
// scroll and a blinking inverted cursor cell.
module vga_tile_framebuffer #(
    parameter int unsigned COLS         = 80,
    parameter int unsigned ROWS         = 60,
    parameter int unsigned CELL_BITS    = 3,
    parameter int unsigned BLINK_FRAMES = 30
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PIX_EN,
    input  logic        REFRESH,
    input  logic [9:0]  ADDRH,
    input  logic [8:0]  ADDRV,
    output logic [11:0] COLOR,
    input  logic        WR_EN,
    input  logic [12:0] WR_ADDR,
    input  logic [11:0] WR_DATA,
    output logic        WR_READY,
    input  logic        CLEAR,
    input  logic [11:0] CLEAR_COLOR,
    input  logic [5:0]  SCROLL_ROW,
    input  logic        CURSOR_EN,
    input  logic [12:0] CURSOR_ADDR
);

    localparam int unsigned CELLS     = COLS * ROWS;
    localparam int unsigned FW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [12:0] LAST_CELL = 13'(CELLS - 1);

    typedef enum logic [0:0] {StIdle, StClearing} state_t;

    state_t        state_q, state_d;
    logic [12:0]   clr_cnt_q, clr_cnt_d;
    logic [11:0]   clr_color_q, clr_color_d;
    logic          wr_ready_q;
    logic [11:0]   color_q;

    logic          ram_we;
    logic [12:0]   ram_waddr;
    logic [11:0]   ram_wdata;
    logic [11:0]   ram [CELLS];

    logic          refresh_q;
    logic          refresh_rise;
    logic [5:0]    scroll_q;
    logic [FW-1:0] frame_cnt_q;
    logic          blink_on_q;

    logic [12:0]   vrow, hcol, row_sum, row, rd_idx;
    logic          in_range, cursor_hit;

    // Pixel address to cell index, with the committed scroll folded into the row.
    always_comb begin
        vrow       = 13'(ADDRV >> CELL_BITS);
        hcol       = 13'(ADDRH >> CELL_BITS);
        row_sum    = vrow + 13'(scroll_q);
        row        = (row_sum >= 13'(ROWS)) ? row_sum - 13'(ROWS) : row_sum;
        rd_idx     = row * 13'(COLS) + hcol;
        in_range   = (ADDRH < 10'(COLS << CELL_BITS)) && (ADDRV < 9'(ROWS << CELL_BITS));
        // rd_idx is always below CELLS when in range, so larger cursor indices never hit.
        cursor_hit = CURSOR_EN && blink_on_q && (rd_idx == CURSOR_ADDR);
    end

    // Registered pixel colour; the read sees RAM contents from before this edge's write.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            color_q <= '0;
        end else if (PIX_EN) begin
            if (in_range) begin
                color_q <= cursor_hit ? ~ram[rd_idx] : ram[rd_idx];
            end else begin
                color_q <= '0;
            end
        end
    end

    // Single RAM write port shared by the processor and the clear engine.
    always_ff @(posedge CLK) begin
        if (ram_we) begin
            ram[ram_waddr] <= ram_wdata;
        end
    end

    // Clear FSM state register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= StIdle;
            clr_cnt_q   <= '0;
            clr_color_q <= '0;
            wr_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_color_q <= clr_color_d;
            wr_ready_q  <= (state_d == StIdle);
        end
    end

    // Clear FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (CLEAR) state_d = StClearing;
            StClearing: if (clr_cnt_q == LAST_CELL) state_d = StIdle;
        endcase
    end

    // Clear FSM outputs: RAM write selection and clear bookkeeping.
    always_comb begin
        ram_we      = 1'b0;
        ram_waddr   = WR_ADDR;
        ram_wdata   = WR_DATA;
        clr_cnt_d   = clr_cnt_q;
        clr_color_d = clr_color_q;
        unique case (state_q)
            StIdle: begin
                ram_we = WR_EN && wr_ready_q && (WR_ADDR < 13'(CELLS));
                if (CLEAR) begin
                    clr_cnt_d   = '0;
                    clr_color_d = CLEAR_COLOR;
                end
            end
            StClearing: begin
                ram_we    = 1'b1;
                ram_waddr = clr_cnt_q;
                ram_wdata = clr_color_q;
                clr_cnt_d = clr_cnt_q + 13'd1;
            end
        endcase
        // Reset aborts any write in flight, leaving earlier cells intact.
        if (RESET) ram_we = 1'b0;
    end

    assign refresh_rise = REFRESH && !refresh_q;

    // Frame events: commit scroll and advance the cursor blink on each REFRESH edge.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            refresh_q   <= 1'b0;
            scroll_q    <= '0;
            frame_cnt_q <= '0;
            blink_on_q  <= 1'b1;
        end else begin
            refresh_q <= REFRESH;
            if (refresh_rise) begin
                if (SCROLL_ROW < 6'(ROWS)) scroll_q <= SCROLL_ROW;
                if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt_q <= '0;
                    blink_on_q  <= !blink_on_q;
                end else begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end
            end
        end
    end

    assign COLOR    = color_q;
    assign WR_READY = wr_ready_q;

endmodule

// File: tb/tb_vga_tile_framebuffer.sv
// Self-checking bench for vga_tile_framebuffer: a cell-level screen model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_vga_tile_framebuffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        pix_en;
    logic        refresh;
    logic [9:0]  addrh;
    logic [8:0]  addrv;
    logic [11:0] color;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [11:0] wr_data;
    logic        wr_ready;
    logic        clear;
    logic [11:0] clear_color;
    logic [5:0]  scroll_row;
    logic        cursor_en;
    logic [12:0] cursor_addr;

    always #5 clk = ~clk;

    vga_tile_framebuffer dut (
        .CLK        (clk),
        .RESET      (reset),
        .PIX_EN     (pix_en),
        .REFRESH    (refresh),
        .ADDRH      (addrh),
        .ADDRV      (addrv),
        .COLOR      (color),
        .WR_EN      (wr_en),
        .WR_ADDR    (wr_addr),
        .WR_DATA    (wr_data),
        .WR_READY   (wr_ready),
        .CLEAR      (clear),
        .CLEAR_COLOR(clear_color),
        .SCROLL_ROW (scroll_row),
        .CURSOR_EN  (cursor_en),
        .CURSOR_ADDR(cursor_addr)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Screen model: the cell store, pending clear work, scroll and blink state.
    logic [11:0] m_mem   [4800];
    bit          m_known [4800];
    bit          m_valid = 1'b0;
    bit          m_clearing;
    int          m_clr_idx;
    logic [11:0] m_clr_col;
    int          m_scroll;
    bit          m_blink_on;
    int          m_frames;
    bit          m_ref_prev;
    logic [11:0] m_color;
    bit          m_color_known;
    bit          m_ready;
    int          m_idx;

    always @(posedge clk) begin
        if (reset) begin
            m_color       = 12'h000;
            m_color_known = 1'b1;
            m_clearing    = 1'b0;
            m_clr_idx     = 0;
            m_scroll      = 0;
            m_blink_on    = 1'b1;
            m_frames      = 0;
            m_ref_prev    = 1'b0;
            m_ready       = 1'b1;
            m_valid       = 1'b1;
        end else begin
            if (pix_en) begin
                if (addrh < 640 && addrv < 480) begin
                    m_idx         = ((addrv / 8 + m_scroll) % 60) * 80 + addrh / 8;
                    m_color       = m_mem[m_idx];
                    m_color_known = m_known[m_idx];
                    if (cursor_en && m_blink_on && m_idx == cursor_addr) m_color = ~m_color;
                end else begin
                    m_color       = 12'h000;
                    m_color_known = 1'b1;
                end
            end
            if (m_clearing) begin
                m_mem[m_clr_idx]   = m_clr_col;
                m_known[m_clr_idx] = 1'b1;
                m_clr_idx++;
                if (m_clr_idx == 4800) m_clearing = 1'b0;
            end else begin
                if (wr_en && wr_addr < 4800) begin
                    m_mem[wr_addr]   = wr_data;
                    m_known[wr_addr] = 1'b1;
                end
                if (clear) begin
                    m_clearing = 1'b1;
                    m_clr_idx  = 0;
                    m_clr_col  = clear_color;
                end
            end
            m_ready = !m_clearing;
            if (refresh && !m_ref_prev) begin
                if (scroll_row < 60) m_scroll = scroll_row;
                m_frames++;
                if (m_frames == 30) begin
                    m_frames   = 0;
                    m_blink_on = !m_blink_on;
                end
            end
            m_ref_prev = refresh;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model wr_ready", {15'd0, wr_ready}, {15'd0, m_ready});
            if (m_color_known) check("model color", {4'd0, color}, {4'd0, m_color});
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_cell(input int addr, input logic [11:0] data);
        wr_en   = 1'b1;
        wr_addr = 13'(addr);
        wr_data = data;
        step(1);
        wr_en   = 1'b0;
    endtask

    task automatic show(input int h, input int v);
        addrh = 10'(h);
        addrv = 9'(v);
        step(1);
    endtask

    task automatic pulse_refresh(input int hold);
        refresh = 1'b1;
        step(hold);
        refresh = 1'b0;
        step(2);
    endtask

    int n;
    logic [11:0] exp_c;

    initial begin
        reset       = 1'b1;
        pix_en      = 1'b0;
        refresh     = 1'b0;
        addrh       = '0;
        addrv       = '0;
        wr_en       = 1'b0;
        wr_addr     = '0;
        wr_data     = '0;
        clear       = 1'b0;
        clear_color = '0;
        scroll_row  = '0;
        cursor_en   = 1'b0;
        cursor_addr = '0;
        step(2);
        reset = 1'b0;
        check("reset color", {4'd0, color}, 16'h0000);
        check("reset wr_ready", {15'd0, wr_ready}, 16'h0001);

        // Basic write and read-back.
        pix_en = 1'b1;
        write_cell(81, 12'hF00);
        write_cell(0, 12'h055);
        show(8, 8);
        check("cell 81 at (8,8)", {4'd0, color}, 16'h0F00);
        show(7, 0);
        check("cell 0 at (7,0)", {4'd0, color}, 16'h0055);

        // Full clear; a write attempted mid-clear must be dropped.
        clear_color = 12'h0A5;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        n = 0;
        while (wr_ready === 1'b0 && n < 6000) begin
            if (n == 3000) begin
                wr_en   = 1'b1;
                wr_addr = 13'd5;
                wr_data = 12'hFFF;
            end else begin
                wr_en = 1'b0;
            end
            step(1);
            n++;
        end
        wr_en = 1'b0;
        check("clear busy cycles", 16'(n), 16'd4800);
        show(0, 0);
        check("cleared cell 0", {4'd0, color}, 16'h00A5);
        show(0, 240);
        check("cleared cell 2400", {4'd0, color}, 16'h00A5);
        show(632, 472);
        check("cleared cell 4799", {4'd0, color}, 16'h00A5);
        show(40, 0);
        check("dropped mid-clear write", {4'd0, color}, 16'h00A5);

        // Scroll commits only on a REFRESH edge; out-of-range values are ignored.
        write_cell(0, 12'h123);
        scroll_row = 6'd59;
        show(0, 8);
        step(5);
        check("scroll held mid-frame", {4'd0, color}, 16'h00A5);
        pulse_refresh(1);
        check("scroll 59 row 1", {4'd0, color}, 16'h0123);
        scroll_row = 6'd60;
        pulse_refresh(1);
        check("scroll 60 ignored", {4'd0, color}, 16'h0123);
        show(0, 0);
        check("scroll 59 row 0", {4'd0, color}, 16'h00A5);

        // Cursor blink: restart blink state from reset.
        scroll_row = 6'd0;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        cursor_en   = 1'b1;
        cursor_addr = 13'd0;
        show(0, 0);
        check("cursor on", {4'd0, color}, 16'h0EDC);
        for (int k = 1; k <= 60; k++) begin
            pulse_refresh(k == 1 ? 100 : 1);
            exp_c = (k >= 30 && k < 60) ? 12'h123 : 12'hEDC;
            check("cursor phase", {4'd0, color}, {4'd0, exp_c});
        end
        cursor_addr = 13'd4800;
        step(1);
        check("cursor addr out of range", {4'd0, color}, 16'h0123);
        cursor_en = 1'b0;
        cursor_addr = 13'd0;

        // Off-screen addresses and PIX_EN hold.
        show(700, 10);
        check("addrh 700", {4'd0, color}, 16'h0000);
        show(0, 500);
        check("addrv 500", {4'd0, color}, 16'h0000);
        show(0, 0);
        check("cell 0 no cursor", {4'd0, color}, 16'h0123);
        pix_en = 1'b0;
        show(8, 8);
        step(2);
        check("pix_en hold", {4'd0, color}, 16'h0123);
        pix_en = 1'b1;

        // Reset in the middle of a clear leaves the first 100 cells cleared.
        write_cell(100, 12'h777);
        clear_color = 12'h3C3;
        clear = 1'b1;
        step(1);
        clear = 1'b0;
        step(100);
        reset = 1'b1;
        step(1);
        check("abort wr_ready", {15'd0, wr_ready}, 16'h0001);
        check("abort color", {4'd0, color}, 16'h0000);
        reset = 1'b0;
        show(152, 8);
        check("abort cell 99", {4'd0, color}, 16'h03C3);
        show(160, 8);
        check("abort cell 100", {4'd0, color}, 16'h0777);
        show(0, 0);
        check("abort cell 0", {4'd0, color}, 16'h03C3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        tests++;
        fails++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
